// File: rtl/sram_dma_pkg.sv
// Shared constants for the SRAM DMA engine: CSR map, op codes, bit indices and FSM states.
package sram_dma_pkg;

  localparam int unsigned LEN_W = 15;

  localparam logic [2:0] CSR_SRC     = 3'd0;
  localparam logic [2:0] CSR_DST     = 3'd1;
  localparam logic [2:0] CSR_LEN     = 3'd2;
  localparam logic [2:0] CSR_PATTERN = 3'd3;
  localparam logic [2:0] CSR_CTRL    = 3'd4;
  localparam logic [2:0] CSR_STATUS  = 3'd5;
  localparam logic [2:0] CSR_SUM     = 3'd6;

  localparam logic [1:0] OP_FILL    = 2'b00;
  localparam logic [1:0] OP_COPY    = 2'b01;
  localparam logic [1:0] OP_SUM     = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_OP_LO  = 1;
  localparam int unsigned CTRL_IRQ_EN = 3;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_ERR  = 2;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CHECK    = 3'd1;
  localparam logic [2:0] ST_FILL     = 3'd2;
  localparam logic [2:0] ST_CP_RD    = 3'd3;
  localparam logic [2:0] ST_CP_WR    = 3'd4;
  localparam logic [2:0] ST_SUM_RUN  = 3'd5;
  localparam logic [2:0] ST_SUM_TAIL = 3'd6;
  localparam logic [2:0] ST_FINISH   = 3'd7;

endpackage

// File: rtl/sram_dma_csr.sv
// CSR slave for the SRAM DMA engine: config registers, W1C status, readback and irq.
module sram_dma_csr
  import sram_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              irq,
  input  logic              busy,
  input  logic              finish_c,
  input  logic              err_set_c,
  input  logic [DATA_W-1:0] sum,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [LEN_W-1:0]  len,
  output logic [31:0]       pattern,
  output logic [1:0]        op,
  output logic              start_c,
  output logic [1:0]        start_op_c
);

  logic        cfg_we_c;
  logic        w1c_c;
  logic        irq_en;
  logic        irq_en_d;
  logic        done;
  logic        done_d;
  logic        err;
  logic        err_d;
  logic [31:0] rd_mux_c;

  // Configuration is frozen while an operation runs; STATUS W1C is always live.
  assign cfg_we_c   = csr_write && !busy;
  assign w1c_c      = csr_write && (csr_address == CSR_STATUS);
  assign start_c    = cfg_we_c && (csr_address == CSR_CTRL) && csr_writedata[CTRL_START];
  assign start_op_c = csr_writedata[CTRL_OP_LO +: 2];

  // Hardware set beats a same-cycle W1C; start clears stale flags.
  always_comb begin
    irq_en_d = irq_en;
    done_d   = done;
    err_d    = err;
    if (cfg_we_c && (csr_address == CSR_CTRL)) irq_en_d = csr_writedata[CTRL_IRQ_EN];
    if (start_c || (w1c_c && csr_writedata[STAT_DONE])) done_d = 1'b0;
    if (finish_c) done_d = 1'b1;
    if (start_c || (w1c_c && csr_writedata[STAT_ERR])) err_d = 1'b0;
    if (err_set_c) err_d = 1'b1;
  end

  always_comb begin
    rd_mux_c = '0;
    case (csr_address)
      CSR_SRC:     rd_mux_c = 32'(src);
      CSR_DST:     rd_mux_c = 32'(dst);
      CSR_LEN:     rd_mux_c = 32'(len);
      CSR_PATTERN: rd_mux_c = pattern;
      CSR_CTRL:    rd_mux_c = {28'd0, irq_en, op, 1'b0};
      CSR_STATUS:  rd_mux_c = {29'd0, err, done, busy};
      CSR_SUM:     rd_mux_c = 32'(sum);
      default:     rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      src          <= '0;
      dst          <= '0;
      len          <= '0;
      pattern      <= '0;
      op           <= '0;
      irq_en       <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      irq          <= 1'b0;
      csr_readdata <= '0;
    end else begin
      if (cfg_we_c) begin
        case (csr_address)
          CSR_SRC:     src     <= ADDR_W'(csr_writedata);
          CSR_DST:     dst     <= ADDR_W'(csr_writedata);
          CSR_LEN:     len     <= LEN_W'(csr_writedata);
          CSR_PATTERN: pattern <= csr_writedata;
          CSR_CTRL:    op      <= csr_writedata[CTRL_OP_LO +: 2];
          default:     ;
        endcase
      end
      irq_en       <= irq_en_d;
      done         <= done_d;
      err          <= err_d;
      irq          <= (done_d || err_d) && irq_en_d;
      csr_readdata <= csr_read ? rd_mux_c : '0;
    end
  end

endmodule

// File: rtl/sram_dma_engine.sv
// Avalon-MM master performing fill, copy and checksum over the on-chip SRAM.
module sram_dma_engine
  import sram_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 10240
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              irq,
  output logic [ADDR_W-1:0] sram_address,
  output logic [3:0]        sram_byteenable,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [DATA_W-1:0] sram_writedata,
  output logic              sram_clken,
  input  logic [DATA_W-1:0] sram_readdata
);

  logic [2:0]        state, state_d;
  logic [LEN_W-1:0]  cnt, cnt_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] sum_q;
  logic              busy;
  logic              finish_c;
  logic              err_set_c;
  logic              sum_acc_c;
  logic              start_c;
  logic [1:0]        start_op_c;
  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0]  len;
  logic [31:0]       pattern;
  logic [1:0]        op;
  logic [15:0]       src_end_c, dst_end_c;
  logic              range_err_c;
  logic              last_c;

  sram_dma_csr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_csr (
    .clk           (clk),
    .reset_n       (reset_n),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata),
    .irq           (irq),
    .busy          (busy),
    .finish_c      (finish_c),
    .err_set_c     (err_set_c),
    .sum           (sum_q),
    .src           (src),
    .dst           (dst),
    .len           (len),
    .pattern       (pattern),
    .op            (op),
    .start_c       (start_c),
    .start_op_c    (start_op_c)
  );

  assign busy            = (state != ST_IDLE);
  assign sram_byteenable = 4'hF;
  assign sram_clken      = 1'b1;
  assign sram_chipselect = cs_q;
  assign sram_write      = we_q;
  assign sram_address    = addr_q;
  // Copy writes forward the read data returned this cycle without a holding register.
  assign sram_writedata  = (state == ST_CP_WR) ? sram_readdata : wdata_q;

  assign src_end_c   = 16'(src) + 16'(len);
  assign dst_end_c   = 16'(dst) + 16'(len);
  assign range_err_c = (op == OP_ILLEGAL)
                    || ((op != OP_SUM)  && (dst_end_c > 16'(DEPTH)))
                    || ((op != OP_FILL) && (src_end_c > 16'(DEPTH)));
  assign last_c      = (cnt == len - LEN_W'(1));

  // Next-state and next-access logic; SRAM strobes are registered from *_d.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    cs_d      = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    finish_c  = 1'b0;
    err_set_c = 1'b0;
    sum_acc_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_c) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        cnt_d = '0;
        if (range_err_c) begin
          err_set_c = 1'b1;
          state_d   = ST_FINISH;
        end else if (len == '0) begin
          state_d = ST_FINISH;
        end else if (op == OP_FILL) begin
          cs_d    = 1'b1;
          we_d    = 1'b1;
          addr_d  = dst;
          wdata_d = pattern;
          state_d = ST_FILL;
        end else if (op == OP_COPY) begin
          cs_d    = 1'b1;
          addr_d  = src;
          state_d = ST_CP_RD;
        end else begin
          cs_d    = 1'b1;
          addr_d  = src;
          state_d = ST_SUM_RUN;
        end
      end
      ST_FILL: begin
        if (last_c) begin
          state_d = ST_FINISH;
        end else begin
          cs_d   = 1'b1;
          we_d   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt + LEN_W'(1);
        end
      end
      ST_CP_RD: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = dst + ADDR_W'(cnt);
        state_d = ST_CP_WR;
      end
      ST_CP_WR: begin
        if (last_c) begin
          state_d = ST_FINISH;
        end else begin
          cs_d    = 1'b1;
          addr_d  = src + ADDR_W'(cnt + LEN_W'(1));
          cnt_d   = cnt + LEN_W'(1);
          state_d = ST_CP_RD;
        end
      end
      ST_SUM_RUN: begin
        // Data for read cnt-1 arrives while read cnt is presented.
        sum_acc_c = (cnt != '0);
        if (last_c) begin
          state_d = ST_SUM_TAIL;
        end else begin
          cs_d   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt + LEN_W'(1);
        end
      end
      ST_SUM_TAIL: begin
        sum_acc_c = 1'b1;
        state_d   = ST_FINISH;
      end
      ST_FINISH: begin
        finish_c = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (start_c && (start_op_c == OP_SUM)) begin
      sum_q <= '0;
    end else if (sum_acc_c) begin
      sum_q <= sum_q + sram_readdata;
    end
  end

endmodule

// File: tb/tb_sram_dma_engine.sv
// Scoreboard bench for sram_dma_engine with an SRAM model and a word-level reference model.
module tb_sram_dma_engine;
  import sram_dma_pkg::*;

  localparam int unsigned DEPTH = 10240;

  typedef struct {
    int unsigned cyc;
    logic        we;
    logic [13:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  csr_address;
  logic        csr_read;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;
  logic        irq;
  logic [13:0] sram_address;
  logic [3:0]  sram_byteenable;
  logic        sram_chipselect;
  logic        sram_write;
  logic [31:0] sram_writedata;
  logic        sram_clken;
  logic [31:0] sram_readdata;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_sum;
  acc_t        acc_q[$];
  rd_t         rd_q[$];
  int unsigned cyc = 0;
  logic        rd_pend = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  sram_dma_engine dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .csr_address     (csr_address),
    .csr_read        (csr_read),
    .csr_write       (csr_write),
    .csr_writedata   (csr_writedata),
    .csr_readdata    (csr_readdata),
    .irq             (irq),
    .sram_address    (sram_address),
    .sram_byteenable (sram_byteenable),
    .sram_chipselect (sram_chipselect),
    .sram_write      (sram_write),
    .sram_writedata  (sram_writedata),
    .sram_clken      (sram_clken),
    .sram_readdata   (sram_readdata)
  );

  // SRAM slave model with one cycle of read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_pend <= (csr_read === 1'b1);
    if (sram_chipselect === 1'b1) begin
      if (sram_write) mem[sram_address] <= sram_writedata;
      else            sram_readdata     <= mem[sram_address];
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every SRAM access and every CSR read response is matched against the queues.
  always @(negedge clk) begin
    acc_t e;
    rd_t  r;
    if (sram_chipselect === 1'b1) begin
      if (acc_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_access: addr %0d we %0b at cycle %0d, none expected",
                 sram_address, sram_write, cyc);
      end else begin
        e = acc_q.pop_front();
        chk("acc_cycle", cyc, e.cyc);
        chk("acc_we", 32'(sram_write), 32'(e.we));
        chk("acc_addr", 32'(sram_address), 32'(e.addr));
        if (e.we) chk("acc_data", sram_writedata, e.data);
        chk("acc_byteenable", 32'(sram_byteenable), 32'hF);
      end
    end
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: got 0x%08h, none expected", csr_readdata);
      end else begin
        r = rd_q.pop_front();
        chk(r.name, csr_readdata, r.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int unsigned c);
    while (cyc < c) tick();
  endtask

  task automatic csr_wr(logic [2:0] a, logic [31:0] d);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    tick();
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(string nm, logic [2:0] a, logic [31:0] e);
    rd_t r;
    r.name = nm;
    r.exp  = e;
    rd_q.push_back(r);
    csr_address = a;
    csr_read    = 1'b1;
    tick();
    csr_read = 1'b0;
  endtask

  task automatic push_acc(int unsigned c, logic we, int unsigned a, logic [31:0] d);
    acc_t e;
    e.cyc  = c;
    e.we   = we;
    e.addr = 14'(a);
    e.data = d;
    acc_q.push_back(e);
  endtask

  function automatic logic [31:0] status(logic b, logic d, logic e);
    return {29'd0, e, d, b};
  endfunction

  task automatic check_mem(string nm);
    int nb = 0;
    for (int k = 0; k < DEPTH; k++) if (mem[k] !== ref_mem[k]) nb++;
    chk(nm, 32'(nb), 32'd0);
  endtask

  // Program, start and fully check one operation against the word-level model.
  task automatic run_op(logic [1:0] op, int unsigned src, int unsigned dst, int unsigned len,
                        logic [31:0] pat, logic ien, logic poke_len);
    int unsigned t, dur;
    logic        err;
    logic [31:0] d;
    csr_wr(CSR_SRC, 32'(src));
    csr_wr(CSR_DST, 32'(dst));
    csr_wr(CSR_LEN, 32'(len));
    csr_wr(CSR_PATTERN, pat);
    err = (op == 2'b11) || (op != 2'b10 && dst + len > DEPTH) || (op != 2'b00 && src + len > DEPTH);
    if (op == 2'b10) ref_sum = '0;
    t = cyc;
    if (err || len == 0) dur = 2;
    else if (op == 2'b00) begin
      dur = len + 2;
      for (int i = 0; i < len; i++) begin
        push_acc(t + 2 + i, 1'b1, dst + i, pat);
        ref_mem[dst + i] = pat;
      end
    end else if (op == 2'b01) begin
      dur = 2 * len + 2;
      for (int i = 0; i < len; i++) begin
        d = ref_mem[src + i];
        push_acc(t + 2 + 2 * i, 1'b0, src + i, '0);
        push_acc(t + 3 + 2 * i, 1'b1, dst + i, d);
        ref_mem[dst + i] = d;
      end
    end else begin
      dur = len + 3;
      for (int i = 0; i < len; i++) begin
        push_acc(t + 2 + i, 1'b0, src + i, '0);
        ref_sum = ref_sum + ref_mem[src + i];
      end
    end
    csr_wr(CSR_CTRL, {28'd0, ien, op, 1'b1});
    if (poke_len) csr_wr(CSR_LEN, 32'h3);
    wait_cyc(t + dur);
    csr_rd("status_last_busy", CSR_STATUS, status(1'b1, 1'b0, err));
    csr_rd("status_done", CSR_STATUS, status(1'b0, 1'b1, err));
    chk("irq_on_done", 32'(irq), 32'(ien));
    csr_rd("sum", CSR_SUM, ref_sum);
    csr_rd("ctrl", CSR_CTRL, {28'd0, ien, op, 1'b0});
    csr_rd("len", CSR_LEN, 32'(len));
    chk("acc_q_drained", 32'(acc_q.size()), 32'd0);
    check_mem("mem_image");
    csr_wr(CSR_STATUS, 32'h2);
    chk("irq_after_w1c", 32'(irq), 32'(err & ien));
    csr_rd("status_w1c", CSR_STATUS, status(1'b0, 1'b0, err));
    csr_wr(CSR_STATUS, 32'h4);
  endtask

  initial begin
    int unsigned t, src, dst, len;
    logic [1:0]  op;
    reset_n       = 1'b0;
    csr_address   = '0;
    csr_read      = 1'b0;
    csr_write     = 1'b0;
    csr_writedata = '0;
    ref_sum       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      mem[k]     = $urandom;
      ref_mem[k] = mem[k];
    end
    repeat (3) tick();
    chk("rst_chipselect", 32'(sram_chipselect), 32'd0);
    chk("rst_write", 32'(sram_write), 32'd0);
    chk("rst_address", 32'(sram_address), 32'd0);
    chk("rst_writedata", sram_writedata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_readdata", csr_readdata, 32'd0);
    chk("clken", 32'(sram_clken), 32'd1);
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) csr_rd("rst_csr", 3'(a), 32'd0);

    // Fill with exact cycle placement.
    run_op(2'b00, 0, 100, 4, 32'hA5A5_0001, 1'b0, 1'b0);
    // Copy, then an overlapping forward copy that must propagate.
    for (int k = 0; k < 3; k++) begin
      mem[k]     = 32'(k + 1);
      ref_mem[k] = 32'(k + 1);
    end
    run_op(2'b01, 0, 200, 3, '0, 1'b0, 1'b0);
    run_op(2'b01, 0, 1, 3, '0, 1'b0, 1'b0);
    chk("overlap_word3", mem[3], 32'd1);
    // Checksum that wraps modulo 2^32.
    mem[10] = 32'hFFFF_FFFF; mem[11] = 32'd1; mem[12] = 32'd5; mem[13] = 32'd7;
    for (int k = 10; k < 14; k++) ref_mem[k] = mem[k];
    run_op(2'b10, 10, 0, 4, '0, 1'b0, 1'b0);
    csr_rd("sum_wrap", CSR_SUM, 32'h0000_000C);
    // Boundaries and illegal op.
    run_op(2'b00, 5, 5, 0, 32'h1234_5678, 1'b0, 1'b0);
    run_op(2'b00, 0, 10239, 2, 32'h1234_5678, 1'b0, 1'b0);
    run_op(2'b01, 10239, 0, 1, '0, 1'b0, 1'b0);
    run_op(2'b11, 0, 0, 4, '0, 1'b1, 1'b0);
    // Interrupt path and a LEN write while busy.
    run_op(2'b00, 0, 300, 3, 32'hDEAD_BEEF, 1'b1, 1'b0);
    run_op(2'b00, 0, 400, 8, 32'hCAFE_0008, 1'b1, 1'b1);

    // Reset in the middle of a copy after two words have been written.
    csr_wr(CSR_SRC, 32'd0);
    csr_wr(CSR_DST, 32'd200);
    csr_wr(CSR_LEN, 32'd6);
    t = cyc;
    for (int i = 0; i < 2; i++) begin
      push_acc(t + 2 + 2 * i, 1'b0, i, '0);
      push_acc(t + 3 + 2 * i, 1'b1, 200 + i, ref_mem[i]);
      ref_mem[200 + i] = ref_mem[i];
    end
    push_acc(t + 6, 1'b0, 2, '0);
    csr_wr(CSR_CTRL, {28'd0, 1'b1, OP_COPY, 1'b1});
    wait_cyc(t + 6);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    ref_sum = '0;
    chk("abort_chipselect", 32'(sram_chipselect), 32'd0);
    chk("abort_irq", 32'(irq), 32'd0);
    for (int a = 0; a < 8; a++) csr_rd("abort_csr", 3'(a), 32'd0);
    chk("abort_acc_q_drained", 32'(acc_q.size()), 32'd0);
    check_mem("abort_mem_image");

    // Randomised operations, some deliberately near the top of memory.
    for (int n = 0; n < 40; n++) begin
      op  = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 12);
      src = ($urandom_range(0, 3) == 0) ? DEPTH - 1 - $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1);
      dst = ($urandom_range(0, 3) == 0) ? DEPTH - 1 - $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 3) == 0) dst = src + $urandom_range(0, 4);
      if (dst >= DEPTH) dst = DEPTH - 1;
      run_op(op, src, dst, len, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (4) tick();
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_dma_engine.md
Name: sram_dma_engine

Overview:
- Avalon-MM master engine directly upstream of the on-chip SRAM slave (32-bit data, 14-bit word address, 10240 words, 1-cycle read latency).
- Performs fill, copy and checksum over SRAM words without Nios II involvement.
- Nios II controls it through a small CSR slave and receives a done interrupt.

Parameters:
- ADDR_W, 14, SRAM word-address width.
- DATA_W, 32, SRAM data width.
- DEPTH, 10240, number of valid SRAM words; used for the range check.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- csr_address  in  3  CSR word select.
- csr_read  in  1  CSR read strobe.
- csr_write  in  1  CSR write strobe.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data, valid the cycle after csr_read.
- irq  out  1  level interrupt.
- sram_address  out  ADDR_W  SRAM word address.
- sram_byteenable  out  4  SRAM byte enables; always 4'hF.
- sram_chipselect  out  1  SRAM access strobe.
- sram_write  out  1  SRAM write, qualified by chipselect.
- sram_writedata  out  DATA_W  SRAM write data.
- sram_clken  out  1  SRAM clock enable; constant 1.
- sram_readdata  in  DATA_W  SRAM read data, valid 1 cycle after a read access.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - All CSRs 0; FSM to IDLE.
  - sram_chipselect=0, sram_write=0, sram_address=0, sram_writedata=0.
  - irq=0, csr_readdata=0.
  - Reset mid-operation aborts immediately; no further SRAM access. Partial writes already made remain in SRAM.
- CSR map:
  - 0 SRC (ADDR_W bits).
  - 1 DST (ADDR_W bits).
  - 2 LEN (15 bits, words).
  - 3 PATTERN (32 bits).
  - 4 CTRL: bit0 start (self-clearing, reads 0), bits2:1 op (00 fill, 01 copy, 10 sum, 11 illegal), bit3 irq_en.
  - 5 STATUS: bit0 busy (RO), bit1 done (W1C), bit2 err (W1C).
  - 6 SUM (RO).
  - 7 reads 0.
- Writes while busy:
  - Writes to regs 0–4 are ignored.
  - STATUS W1C is always honoured.
  - A W1C in the same cycle as hardware setting done: the set wins.
- irq = (done | err) & irq_en, registered.
- FSM states: IDLE, CHECK, FILL, CP_RD, CP_WR, SUM_RUN, SUM_TAIL, FINISH.
- Start and CHECK:
  - A start write in cycle T (while idle) latches the op, sets busy, and clears done, err and (for sum) SUM.
  - The FSM is in CHECK at T+1.
  - CHECK sets err and goes to FINISH (no SRAM access) if any of:
    - op=11;
    - for fill/copy, DST+LEN > DEPTH;
    - for copy/sum, SRC+LEN > DEPTH.
    - Sums are computed in 16-bit arithmetic.
  - LEN=0 goes to FINISH with err=0 and no access.
  - Otherwise the first SRAM access is at T+2.
- FILL: one write per cycle, address DST+i, data PATTERN. LEN cycles total.
- COPY: strictly forward, 2 cycles per word.
  - CP_RD issues a read at SRC+i.
  - CP_WR writes DST+i with sram_readdata taken directly that cycle.
  - Overlapping ranges behave as a sequential forward word copy: when DST>SRC and the ranges overlap, the data propagates.
- SUM:
  - Reads issued back-to-back from SRC+i.
  - Each word is accumulated into SUM (mod 2^32) in the cycle its data returns.
  - SUM_TAIL absorbs the final word.
  - LEN+1 cycles total.
- FINISH (one cycle): clears busy and sets done. SUM is stable from then on.
- Address counter: ADDR_W bits. No wrap is possible because the range check precedes every access.

Decomposition:
- Shared package sram_dma_pkg:
  - CSR offset constants;
  - op codes FILL/COPY/SUM;
  - STATUS/CTRL bit indices;
  - FSM state enum.
- One sub-module, sram_dma_csr: register file, W1C logic, csr_readdata and irq. The datapath and FSM stay in the top.

Test Plan:
- Fill: SRC=0, DST=100, LEN=4, PATTERN=0xA5A5_0001, start -> writes at 100..103 in cycles T+2..T+5; done at T+7; readback all = 0xA5A5_0001.
- Copy: preload [0..2]={1,2,3}; copy SRC=0, DST=200, LEN=3 -> alternating rd/wr for 6 cycles; [200..202]={1,2,3}; done set. Overlap case SRC=0, DST=1, LEN=3 -> [1..3]={1,1,1}.
- Sum: [10..13]={0xFFFF_FFFF,1,5,7}, LEN=4 -> SUM=0x0000_000C (wrap); busy exactly LEN+3 cycles after start.
- Boundaries:
  - LEN=0 -> done, err=0, no chipselect.
  - DST=10239, LEN=2 fill -> err=1, no access.
  - op=11 -> err=1.
- Control: irq_en=1 fill completes -> irq=1; STATUS write 0x2 -> done and irq clear next cycle. A write to LEN while busy is ignored (readback unchanged).
- Reset mid-copy after 2 words: reset_n=0 for one cycle -> chipselect=0 next cycle, all CSRs 0, only the first 2 destination words modified.
